// File: rtl/toy_dispatch_eu_arbiter.sv
// Per-cycle issue scheduler: one round-robin grant per execution unit, gated by per-EU credits.
// Optional per-EU stall counters are built only when TOY_DISPATCH_ARB_PERF_EN is defined.
module toy_dispatch_eu_arbiter #(
  parameter int OOO_DEPTH  = 8,
  parameter int CREDIT_MAX = 4,
  parameter int CREDIT_W   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [OOO_DEPTH-1:0]               v_req,
  input  logic [OOO_DEPTH-1:0][3:0]          v_req_goto,
  input  logic                               flush,
  input  logic [3:0]                         eu_credit_ret,
  output logic [OOO_DEPTH-1:0]               v_issue_en,
  output logic [3:0]                         eu_grant,
  output logic [3:0][CREDIT_W-1:0]           eu_credit,
  output logic [3:0]                         eu_busy,
  output logic                               cred_err,
  output logic [3:0][15:0]                   perf_stall_cnt
);

  localparam int                  PTR_W = (OOO_DEPTH > 1) ? $clog2(OOO_DEPTH) : 1;
  localparam logic [CREDIT_W-1:0] CMAX  = CREDIT_W'(CREDIT_MAX);

  logic [3:0][PTR_W-1:0]     r_rr_ptr;
  logic [3:0][CREDIT_W-1:0]  r_credit;
  logic                      r_err;

  logic [3:0][OOO_DEPTH-1:0] w_req;
  logic [OOO_DEPTH-1:0]      w_multi;
  logic [3:0]                w_elig;
  logic [3:0][PTR_W-1:0]     w_gidx;
  logic [PTR_W-1:0]          w_idx;
  logic [OOO_DEPTH-1:0]      w_issue;
  logic [3:0]                w_ovf;
  logic [3:0]                w_goto;

  // Lowest set target bit wins; extra bits only raise the error flag.
  always_comb begin
    w_req   = '0;
    w_multi = '0;
    w_goto  = '0;
    for (int i = 0; i < OOO_DEPTH; i++) begin
      w_goto      = v_req_goto[i];
      w_req[0][i] = v_req[i] & w_goto[0];
      w_req[1][i] = v_req[i] & w_goto[1] & ~w_goto[0];
      w_req[2][i] = v_req[i] & w_goto[2] & ~(|w_goto[1:0]);
      w_req[3][i] = v_req[i] & w_goto[3] & ~(|w_goto[2:0]);
      w_multi[i]  = v_req[i] & (|(w_goto & (w_goto - 4'd1)));
    end
  end

  // Descending scan so the first requester at or above the pointer overwrites the rest.
  always_comb begin
    w_elig  = '0;
    w_gidx  = '0;
    w_idx   = '0;
    w_issue = '0;
    for (int e = 0; e < 4; e++) begin
      w_elig[e] = (|w_req[e]) && (r_credit[e] != '0) && !flush && !rst;
      for (int k = OOO_DEPTH - 1; k >= 0; k--) begin
        w_idx = r_rr_ptr[e] + PTR_W'(k);
        if (w_req[e][w_idx]) w_gidx[e] = w_idx;
      end
      if (w_elig[e]) w_issue[w_gidx[e]] = 1'b1;
    end
  end

  always_comb begin
    w_ovf = '0;
    for (int e = 0; e < 4; e++)
      w_ovf[e] = eu_credit_ret[e] && !w_elig[e] && (r_credit[e] == CMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_credit <= {4{CMAX}};
      r_err    <= 1'b0;
    end else begin
      for (int e = 0; e < 4; e++) begin
        if (w_elig[e]) r_rr_ptr[e] <= w_gidx[e] + PTR_W'(1);
        case ({w_elig[e], eu_credit_ret[e]})
          2'b10:   r_credit[e] <= r_credit[e] - CREDIT_W'(1);
          2'b01:   if (r_credit[e] != CMAX) r_credit[e] <= r_credit[e] + CREDIT_W'(1);
          default: r_credit[e] <= r_credit[e];
        endcase
      end
      if ((|w_multi) || (|w_ovf)) r_err <= 1'b1;
    end
  end

`ifdef TOY_DISPATCH_ARB_PERF_EN
  logic [3:0][15:0] r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else begin
      for (int e = 0; e < 4; e++)
        if ((|w_req[e]) && !w_elig[e] && (r_stall[e] != 16'hFFFF))
          r_stall[e] <= r_stall[e] + 16'd1;
    end
  end

  assign perf_stall_cnt = r_stall;
`else
  assign perf_stall_cnt = '0;
`endif

  assign v_issue_en = w_issue;
  assign eu_grant   = w_elig;
  assign eu_credit  = r_credit;
  assign cred_err   = r_err;

  always_comb begin
    eu_busy = '0;
    for (int e = 0; e < 4; e++) eu_busy[e] = (r_credit[e] == '0);
  end

endmodule
